// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit for EXE; holds {HI,LO} until the stage advances.
// Define MUL_ACC_EN to add MADD/MADDU/MSUB/MSUBU (accumulate onto the captured hilo_i).
module muldiv_unit #(
   parameter int MUL_STAGES = 2,
   parameter int DIV_ITERS  = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic [63:0] hilo_i,
   input  logic        cancel_i,
   input  logic        advance_i,
   output logic        busy_o,
   output logic        result_valid_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
   state_e state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic is_mul, is_div, is_acc, sgn, launch, mul_last, lat1;
   logic div_q, nq_q, nr_q, dz_q;
   logic signed [65:0] prod;
   logic [63:0] mp_q [MUL_STAGES];
   logic [63:0] res;
   logic [31:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
   logic [31:0] mag_a, mag_b, s_rem, s_dvd, s_dvs;
   logic [32:0] shl, diff;
   logic unused_prod;

   assign is_div = op_i == 4'd3 || op_i == 4'd4;
`ifdef MUL_ACC_EN
   assign is_acc = op_i >= 4'd5 && op_i <= 4'd8;
`else
   assign is_acc = 1'b0;
`endif
   assign is_mul = op_i == 4'd1 || op_i == 4'd2 || is_acc;
   assign sgn    = op_i == 4'd1 || op_i == 4'd3 || op_i == 4'd5 || op_i == 4'd7;
   assign launch = state_q == IDLE && start_i && !cancel_i && (is_mul || is_div);
   // Cancel drops busy in the same cycle so the controller can take the flush
   assign busy_o         = !cancel_i && (launch || state_q == MUL || state_q == DIV);
   assign result_valid_o = !cancel_i && state_q == DONE;

   assign prod = $signed({sgn & src_a_i[31], src_a_i}) * $signed({sgn & src_b_i[31], src_b_i});
   assign unused_prod = ^prod[65:64];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MUL_STAGES; i++) mp_q[i] <= '0;
      end else begin
         if (launch && is_mul) mp_q[0] <= prod[63:0];
         for (int i = 1; i < MUL_STAGES; i++) mp_q[i] <= mp_q[i-1];
      end
   end

`ifdef MUL_ACC_EN
   logic acc_q, sub_q;
   logic [63:0] hilo_q, accr_q;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q  <= 1'b0;
         sub_q  <= 1'b0;
         hilo_q <= '0;
         accr_q <= '0;
      end else begin
         if (launch) begin
            acc_q  <= is_acc;
            sub_q  <= op_i == 4'd7 || op_i == 4'd8;
            hilo_q <= hilo_i;
         end
         if (state_q == MUL) accr_q <= sub_q ? hilo_q - mp_q[MUL_STAGES-1] : hilo_q + mp_q[MUL_STAGES-1];
      end
   end
   assign mul_last = cnt_q == (acc_q ? 6'(MUL_STAGES) : 6'(MUL_STAGES - 1));
   assign lat1     = !is_acc && MUL_STAGES == 1;
   assign res      = div_q ? {rem_q, dvd_q} : acc_q ? accr_q : mp_q[MUL_STAGES-1];
`else
   logic unused_hilo;
   assign unused_hilo = ^hilo_i;
   assign mul_last = cnt_q == 6'(MUL_STAGES - 1);
   assign lat1     = MUL_STAGES == 1;
   assign res      = div_q ? {rem_q, dvd_q} : mp_q[MUL_STAGES-1];
`endif
   assign {hi_o, lo_o} = state_q == DONE ? res : 64'd0;

   // Restoring divide on magnitudes; the first step runs on the raw inputs in the launch cycle
   assign mag_a = sgn && src_a_i[31] ? -src_a_i : src_a_i;
   assign mag_b = sgn && src_b_i[31] ? -src_b_i : src_b_i;
   assign s_rem = state_q == DIV ? rem_q : 32'd0;
   assign s_dvd = state_q == DIV ? dvd_q : mag_a;
   assign s_dvs = state_q == DIV ? dvs_q : mag_b;
   assign shl   = {s_rem, s_dvd[31]};
   assign diff  = shl - {1'b0, s_dvs};

   always_comb begin
      rem_d = rem_q;
      dvd_d = dvd_q;
      dvs_d = launch ? mag_b : dvs_q;
      if (state_q == DIV && cnt_q == 6'(DIV_ITERS)) begin
         rem_d = nr_q ? -rem_q : rem_q;
         dvd_d = dz_q ? 32'hFFFF_FFFF : nq_q ? -dvd_q : dvd_q;
      end else if ((launch && is_div) || state_q == DIV) begin
         rem_d = diff[32] ? shl[31:0] : diff[31:0];
         dvd_d = {s_dvd[30:0], !diff[32]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (cancel_i) state_d = IDLE;
      else begin
         case (state_q)
            IDLE: if (launch) begin
               state_d = is_div ? DIV : lat1 ? DONE : MUL;
               cnt_d   = 6'd1;
            end
            MUL: begin
               state_d = mul_last ? DONE : MUL;
               cnt_d   = cnt_q + 6'd1;
            end
            DIV: begin
               state_d = cnt_q == 6'(DIV_ITERS) ? DONE : DIV;
               cnt_d   = cnt_q + 6'd1;
            end
            default: state_d = advance_i ? IDLE : DONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         div_q   <= 1'b0;
         nq_q    <= 1'b0;
         nr_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         if (launch) begin
            div_q <= is_div;
            nq_q  <= sgn & (src_a_i[31] ^ src_b_i[31]);
            nr_q  <= sgn & src_a_i[31];
            dz_q  <= src_b_i == 32'd0;
         end
      end
   end
endmodule
